main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  7  instruction opcode field (instr[6:0]), sampled while in DECODE.
REQ-005 mem_ready  input  1  memory handshake; high = the current access completes this cycle.
REQ-006 ALUOp  output  2  00 add, 01 sub (beq), 10 decode funct3/funct7; feeds the ALU decoder.
REQ-007 ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1.
REQ-008 ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-009 ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-010 AdrSrc  output  1  memory address select: 0 PC, 1 Result.
REQ-011 IRWrite, PCUpdate, RegWrite, MemWrite, Branch  output  1 each  enable strobes.
REQ-012 illegal_instr  output  1  sticky flag: an unsupported opcode was decoded.
REQ-013 state_dbg  output  4  current state encoding, for debug only.

Function
REQ-014 Outputs SHALL be Moore: a pure combinational function of the state register; any signal not listed for a state SHALL be 0.
REQ-015 States SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, ILLEGAL.
REQ-016 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- IRWrite=1 and PCUpdate=1 only while mem_ready=1.
- Next state is DECODE on mem_ready, otherwise stay in FETCH.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other value -> ILLEGAL
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op=0000011, else MEMWRITE.
REQ-019 MEMREAD: ResultSrc=00, AdrSrc=1; wait for mem_ready, then -> MEMWB.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-021 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, held every cycle until mem_ready; then -> FETCH.
REQ-022 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> ALUWB.
REQ-023 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; -> ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB.
REQ-026 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
REQ-027 ILLEGAL: all strobes 0, illegal_instr=1; the block stays in ILLEGAL until reset.
REQ-028 op SHALL be ignored in every state except DECODE and MEMADR.
REQ-029 mem_ready SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE.
REQ-030 Instruction latency with mem_ready tied high:
- lw: 5 cycles
- sw: 4 cycles
- R-type, I-type ALU, jal: 4 cycles
- beq: 3 cycles
REQ-031 Unreachable state encodings SHALL return to FETCH on the next clock with all strobes 0.

Reset
REQ-032 rst_n low SHALL force state FETCH asynchronously, regardless of the current state, including mid-access.
REQ-033 During reset, MemWrite, RegWrite, Branch and illegal_instr SHALL be 0; other outputs SHALL take their FETCH values with mem_ready gating applied.
REQ-034 The first state transition SHALL occur on the first rising clk edge after rst_n deasserts.

Structure
REQ-035 The shared package riscv_ctrl_pkg SHALL hold the state enumeration, the opcode constants, and the ALUOp/ALUSrcA/ALUSrcB/ResultSrc encodings.
REQ-036 main_fsm SHALL contain no sub-module: one state register, one next-state block and one output block.
- The controller top level instantiates it beside the ALU decoder and wires ALUOp between them.

Verification
REQ-037 Reset, then lw (op=0000011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5.
REQ-038 sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-039 beq (op=1100011) -> Branch=1 and ALUOp=01 in cycle 3; next state FETCH.
REQ-040 op=1111111 in DECODE -> ILLEGAL, illegal_instr=1 held for 10 cycles; rst_n pulse -> FETCH, illegal_instr=0.
REQ-041 rst_n asserted mid-MEMREAD with mem_ready=0 -> state_dbg equals FETCH immediately (before the next clk edge) and all strobes drop.
REQ-042 FETCH with mem_ready=0 for 2 cycles -> IRWrite=0 and PCUpdate=0 in both cycles, then 1 in the cycle mem_ready rises.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V controller:
// FSM states, opcode constants and the datapath mux select codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10,
      ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // State entered from DECODE for a given opcode.
   function automatic state_t decode_target(input logic [6:0] op);
      state_t s;
      case (op)
         OP_LOAD, OP_STORE: s = MEMADR;
         OP_RTYPE:          s = EXECUTER;
         OP_ITYPE:          s = EXECUTEI;
         OP_JAL:            s = JAL;
         OP_BEQ:            s = BEQ;
         default:           s = ILLEGAL;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: one state register, one next-state
// block and one Moore output block (IRWrite/PCUpdate gated by mem_ready in FETCH).
module main_fsm
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCUpdate,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       Branch,
   output logic       illegal_instr,
   output logic [3:0] state_dbg
);

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = mem_ready ? DECODE : FETCH;
         DECODE:   state_d = decode_target(op);
         MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
         MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         JAL:      state_d = ALUWB;
         BEQ:      state_d = FETCH;
         ILLEGAL:  state_d = ILLEGAL;
         default:  state_d = FETCH;
      endcase
   end

   always_comb begin
      ALUOp         = '0;
      ALUSrcA       = '0;
      ALUSrcB       = '0;
      ResultSrc     = '0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCUpdate      = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      Branch        = 1'b0;
      illegal_instr = 1'b0;
      case (state_q)
         FETCH: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALUOP_ADD;
            ResultSrc = RES_ALURESULT;
            IRWrite   = mem_ready;
            PCUpdate  = mem_ready;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
         end
         MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
         end
         MEMREAD: begin
            ResultSrc = RES_ALUOUT;
            AdrSrc    = 1'b1;
         end
         MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            ResultSrc = RES_ALUOUT;
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
         end
         EXECUTER: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            ALUOp   = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
         end
         ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
         end
         JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALUOP_ADD;
            ResultSrc = RES_ALUOUT;
            PCUpdate  = 1'b1;
         end
         BEQ: begin
            ALUSrcA   = SRCA_RD1;
            ALUSrcB   = SRCB_RD2;
            ALUOp     = ALUOP_SUB;
            ResultSrc = RES_ALUOUT;
            Branch    = 1'b1;
         end
         ILLEGAL: illegal_instr = 1'b1;
         default: ;
      endcase
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: an instruction-plan queue model plus directed scenarios,
// followed by randomized opcodes, memory stalls and asynchronous resets.
module tb_main_fsm;
   import riscv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = '0;
   logic       mem_ready = 1'b0;
   logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
   logic       AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, illegal_instr;
   logic [3:0] state_dbg;

   int unsigned checks = 0;
   int unsigned passed = 0;

   main_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .Branch(Branch), .illegal_instr(illegal_instr),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] aluop, srca, srcb, res;
      logic adr, irw, pcu, rw, mw, br, ill;
   } ctl_t;

   // Remaining steps of the instruction in flight; plan[0] is the current step.
   state_t plan[$];

   function automatic ctl_t exp_ctl(input state_t s, input logic mr);
      ctl_t c = '0;
      case (s)
         FETCH:    begin c.srcb = 2'd2; c.res = 2'd2; c.irw = mr; c.pcu = mr; end
         DECODE:   begin c.srca = 2'd1; c.srcb = 2'd1; end
         MEMADR:   begin c.srca = 2'd2; c.srcb = 2'd1; end
         MEMREAD:  c.adr = 1'b1;
         MEMWB:    begin c.res = 2'd1; c.rw = 1'b1; end
         MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; end
         EXECUTER: begin c.srca = 2'd2; c.aluop = 2'd2; end
         EXECUTEI: begin c.srca = 2'd2; c.srcb = 2'd1; c.aluop = 2'd2; end
         ALUWB:    c.rw = 1'b1;
         JAL:      begin c.srca = 2'd1; c.srcb = 2'd2; c.pcu = 1'b1; end
         BEQ:      begin c.srca = 2'd2; c.aluop = 2'd1; c.br = 1'b1; end
         ILLEGAL:  c.ill = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic compare();
      ctl_t e;
      e = exp_ctl(plan[0], mem_ready);
      check("state_dbg", int'(state_dbg), int'(plan[0]));
      check("ALUOp", int'(ALUOp), int'(e.aluop));
      check("ALUSrcA", int'(ALUSrcA), int'(e.srca));
      check("ALUSrcB", int'(ALUSrcB), int'(e.srcb));
      check("ResultSrc", int'(ResultSrc), int'(e.res));
      check("AdrSrc", int'(AdrSrc), int'(e.adr));
      check("IRWrite", int'(IRWrite), int'(e.irw));
      check("PCUpdate", int'(PCUpdate), int'(e.pcu));
      check("RegWrite", int'(RegWrite), int'(e.rw));
      check("MemWrite", int'(MemWrite), int'(e.mw));
      check("Branch", int'(Branch), int'(e.br));
      check("illegal_instr", int'(illegal_instr), int'(e.ill));
   endtask

   task automatic model_step();
      state_t cur;
      cur = plan[0];
      if (cur == ILLEGAL) return;
      if ((cur == FETCH || cur == MEMREAD || cur == MEMWRITE) && !mem_ready) return;
      void'(plan.pop_front());
      if (cur == FETCH) plan.push_back(DECODE);
      else if (cur == DECODE) begin
         if (op == OP_LOAD || op == OP_STORE) plan.push_back(MEMADR);
         else if (op == OP_RTYPE) begin plan.push_back(EXECUTER); plan.push_back(ALUWB); end
         else if (op == OP_ITYPE) begin plan.push_back(EXECUTEI); plan.push_back(ALUWB); end
         else if (op == OP_JAL)   begin plan.push_back(JAL);      plan.push_back(ALUWB); end
         else if (op == OP_BEQ)   plan.push_back(BEQ);
         else                     plan.push_back(ILLEGAL);
      end else if (cur == MEMADR) begin
         if (op == OP_LOAD) begin plan.push_back(MEMREAD); plan.push_back(MEMWB); end
         else plan.push_back(MEMWRITE);
      end
      if (plan.size() == 0) plan.push_back(FETCH);
   endtask

   // Called just after a negedge: apply inputs, then check settled outputs.
   task automatic drive(input logic [6:0] o, input logic mr);
      op = o;
      mem_ready = mr;
      #1;
      compare();
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Asynchronous reset from mid-cycle, checked before any clock edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      plan.delete();
      plan.push_back(FETCH);
      #1;
      compare();
      check("rst_state_immediate", int'(state_dbg), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [6:0] valid_ops [6];

   initial begin
      valid_ops[0] = OP_LOAD;  valid_ops[1] = OP_STORE; valid_ops[2] = OP_RTYPE;
      valid_ops[3] = OP_ITYPE; valid_ops[4] = OP_JAL;   valid_ops[5] = OP_BEQ;
      plan.push_back(FETCH);

      // Reset state
      @(negedge clk);
      drive(7'h00, 1'b0);
      check("reset_state", int'(state_dbg), 0);
      check("reset_memwrite", int'(MemWrite), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // lw with mem_ready high: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
      for (int i = 0; i < 5; i++) begin
         drive(OP_LOAD, 1'b1);
         check("lw_state", int'(state_dbg), i);
         check("lw_regwrite", int'(RegWrite), (i == 4) ? 1 : 0);
         tick();
      end
      drive(OP_RTYPE, 1'b1);
      check("lw_back_to_fetch", int'(state_dbg), 0);

      // sw with MEMWRITE stalled three cycles
      tick();
      drive(OP_STORE, 1'b1);
      tick();
      drive(OP_STORE, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(OP_STORE, (i == 3));
         check("sw_memwrite_held", int'(MemWrite), 1);
         tick();
      end
      drive(OP_BEQ, 1'b1);
      check("sw_then_fetch", int'(state_dbg), 0);

      // beq: Branch and SUB in cycle 3, then FETCH
      tick();
      drive(OP_BEQ, 1'b1);
      tick();
      drive(OP_BEQ, 1'b1);
      check("beq_branch", int'(Branch), 1);
      check("beq_aluop", int'(ALUOp), 1);
      tick();
      drive(7'h7f, 1'b0);
      check("beq_then_fetch", int'(state_dbg), 0);

      // FETCH stalled two cycles, then mem_ready rises
      for (int i = 0; i < 3; i++) begin
         drive(7'h7f, (i == 2));
         check("fetch_irwrite", int'(IRWrite), (i == 2) ? 1 : 0);
         check("fetch_pcupdate", int'(PCUpdate), (i == 2) ? 1 : 0);
         tick();
      end

      // op=1111111 in DECODE -> ILLEGAL, sticky for 10 cycles
      drive(7'h7f, 1'b1);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(7'($urandom), 1'($urandom));
         check("illegal_sticky", int'(illegal_instr), 1);
         tick();
      end
      do_reset();
      drive(OP_LOAD, 1'b1);
      check("illegal_cleared", int'(illegal_instr), 0);

      // Reset mid-MEMREAD while the access is stalled
      tick();
      drive(OP_LOAD, 1'b1);
      tick();
      drive(OP_LOAD, 1'b1);
      tick();
      drive(OP_LOAD, 1'b0);
      check("in_memread", int'(state_dbg), 3);
      check("memread_adrsrc", int'(AdrSrc), 1);
      do_reset();
      check("rst_adrsrc_drop", int'(AdrSrc), 0);
      check("rst_regwrite_drop", int'(RegWrite), 0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         int unsigned sel;
         logic [6:0] o;
         sel = $urandom_range(0, 24);
         o = (sel < 24) ? valid_ops[sel % 6] : 7'($urandom);
         drive(o, ($urandom_range(0, 3) != 0));
         if (plan[0] == ILLEGAL && $urandom_range(0, 3) == 0) do_reset();
         else if ($urandom_range(0, 99) == 0) do_reset();
         else tick();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
